snes_pad_reader: RTL and testbench
==================================

Name: snes_pad_reader

Overview:
- Serial reader for two SNES-style game controllers wired to the GPIO header.
- Drives the shared LATCH and CLK lines and shifts in one 16-bit button word per player per frame.
- Presents stable, active-high button registers that the MMIO block maps for the processor.
- This is the reading side of the controller's serial shift-out protocol.

Parameters:
- CLK_DIV, 300: system clocks per half-period "tick" (6 us at 50 MHz); must be >= 4.
- POLL_PERIOD, 833000: idle clocks between frames (~16.7 ms at 50 MHz); must be >= 1.
- NUM_BITS, 16: data bits captured per frame.

Ports:
- clock  in  1  system clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- pad_data_p1  in  1  raw serial data, player 1; active-low, asynchronous to clock.
- pad_data_p2  in  1  raw serial data, player 2; active-low, asynchronous to clock.
- poll_req  in  1  single-cycle request to start a frame immediately.
- pad_latch  out  1  LATCH line to both pads.
- pad_clk  out  1  CLK line to both pads; idles high.
- buttons_p1  out  NUM_BITS  last complete word, player 1; 1 = pressed.
- buttons_p2  out  NUM_BITS  last complete word, player 2; 1 = pressed.
- frame_valid  out  1  one-cycle pulse when the buttons registers update.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset: pad_latch=0, pad_clk=1, buttons_p1/p2=0, frame_valid=0, busy=0; state IDLE; tick counter, poll counter and bit counter cleared.
- Reset mid-frame: abort the frame; buttons keep the reset value 0.
- Input synchronisation: each pad_data input passes through a 2-flop synchroniser. Sampled value = inverted synchronised level.
- Tick generator: counts 0..CLK_DIV-1. It is cleared on every state entry, so phase lengths are exact multiples of CLK_DIV.
- IDLE:
  - poll counter increments each cycle.
  - Go to LATCH when the poll counter reaches POLL_PERIOD-1 or poll_req=1.
  - Clear the poll counter on exit.
- LATCH:
  - pad_latch=1, busy=1, for 2 ticks.
  - At the last cycle, capture bit 0 of both shift registers; bit counter=1; go to CLK_LO.
- CLK_LO: pad_clk=0 for 1 tick; then CLK_HI.
- CLK_HI:
  - pad_clk=1 for 1 tick.
  - At its last cycle, if bit counter < NUM_BITS: capture bit[bit counter], increment the counter, go to CLK_LO.
  - Otherwise go to DONE.
  - Exactly NUM_BITS clock pulses are issued per frame; the final pulse carries no sample.
- DONE (1 cycle):
  - Copy both shift registers to buttons_p1/p2 in the same cycle; frame_valid=1; busy=0 next cycle; go to IDLE.
  - Outputs never show a partial frame.
- Frame timing: LATCH start to frame_valid = (2 + 2*NUM_BITS)*CLK_DIV + 1 clocks (137 for CLK_DIV=4, NUM_BITS=16).
- poll_req: ignored when not in IDLE; no queueing.
- Simultaneous poll_req and poll-timer expiry: a single frame starts.
- Bit mapping (NUM_BITS=16):
  - 0 B, 1 Y, 2 SELECT, 3 START, 4 UP, 5 DOWN, 6 LEFT, 7 RIGHT.
  - 8 A, 9 X, 10 L, 11 R.
  - 12-15 reserved; standard pads return 0 for these.

Optional Feature:
- Macro: SNES_PAD_DETECT_EN.
- Defined:
  - Add outputs connected_p1 and connected_p2 (1 bit each, reset 0).
  - In the final CLK_HI, sample each synchronised data line.
  - Connected pads drive low after the last bit; an absent pad floats high via pull-up.
  - connected_pN = (level == 0); updates in the DONE cycle alongside the buttons.
  - When connected_pN = 0, buttons_pN is forced to 0.
- Undefined: the ports do not exist; no extra sample is taken.

Decomposition:
- Package snes_pkg holds:
  - the state enum IDLE/LATCH/CLK_LO/CLK_HI/DONE;
  - localparams for button bit indices BTN_B..BTN_R;
  - LATCH_TICKS=2.
- Sub-module snes_tick_gen: CLK_DIV counter with synchronous clear, emitting a single-cycle tick_end pulse.

Test Plan:
- Reset release, CLK_DIV=4, POLL_PERIOD=100 -> pad_latch rises 100 clocks after reset deasserts. The latch is high for 8 clocks, then 16 low/high pulses of 4+4 clocks follow. frame_valid fires 137 clocks after latch rise.
- Pad model shifts 16'hFEFE (active-low), i.e. B and A pressed -> buttons_p1=16'h0101. No buttons pressed on pad 2 -> buttons_p2=16'h0000.
- poll_req pulsed in IDLE -> latch rises on the next cycle. poll_req pulsed at cycle 50 of a frame -> no second frame, busy unaffected.
- reset asserted during the 9th CLK_HI -> next cycle pad_clk=1, pad_latch=0, buttons=0. The next frame starts after a full POLL_PERIOD.
- Button word changes between two frames (0x0001 -> 0x0800) -> buttons_p1 holds 0x0001 until the DONE cycle, then 0x0800 with frame_valid=1.
- With SNES_PAD_DETECT_EN, pad 2 data tied high -> connected_p2=0, buttons_p2=0. A present pad 1 -> connected_p1=1.

Source files
------------

// File: rtl/snes_pkg.sv
// snes_pkg
// Shared definitions for the SNES controller reader:
//   - snes_state_t : reader FSM states (IDLE, LATCH, CLK_LO, CLK_HI, DONE)
//   - BTN_*        : bit positions of each button in the captured word
//   - LATCH_TICKS  : number of ticks the LATCH line is held high
// No ports (package).

package snes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LO,
        CLK_HI,
        DONE
    } snes_state_t;

    // Order in which a standard pad shifts its buttons out
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    localparam int LATCH_TICKS = 2;

endpackage

// File: rtl/snes_tick_gen.sv
// snes_tick_gen
// Half-period tick generator for the pad serial interface. Counts
// 0..CLK_DIV-1 and flags the last count of each tick.
// Ports:
//   clock     in  system clock
//   reset     in  synchronous active-high reset
//   i_clear   in  synchronous clear, restarts the tick at count 0
//   o_tickEnd out high during the last cycle of every tick

module snes_tick_gen #(
    parameter int CLK_DIV = 300
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    output logic o_tickEnd
);

    localparam int              CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_count;

    // Free-running modulo-CLK_DIV counter; the clear lets the FSM line
    // every phase up with a fresh tick so phase lengths are exact.
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (r_count == CNT_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tickEnd = (r_count == CNT_LAST);

endmodule

// File: rtl/snes_pad_reader.sv
// snes_pad_reader
// Reads two SNES-style controllers sharing LATCH and CLK lines and
// presents one stable, active-high button word per player per frame.
// Frames start every POLL_PERIOD idle clocks or on poll_req.
// Ports:
//   clock, reset               system clock, synchronous active-high reset
//   pad_data_p1/p2        in   raw active-low serial data (asynchronous)
//   poll_req              in   single-cycle request to start a frame now
//   pad_latch, pad_clk    out  LATCH and CLK lines to both pads
//   buttons_p1/p2         out  last complete word, 1 = pressed
//   frame_valid           out  one-cycle pulse when buttons update
//   busy                  out  high while a frame is in progress
// Optional: define SNES_PAD_DETECT_EN to add connected_p1/connected_p2,
// which report whether each pad drove its data line low after the last bit.

module snes_pad_reader
    import snes_pkg::*;
#(
    parameter int CLK_DIV     = 300,
    parameter int POLL_PERIOD = 833000,
    parameter int NUM_BITS    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pad_data_p1,
    input  logic                pad_data_p2,
    input  logic                poll_req,
    output logic                pad_latch,
    output logic                pad_clk,
    output logic [NUM_BITS-1:0] buttons_p1,
    output logic [NUM_BITS-1:0] buttons_p2,
    output logic                frame_valid,
`ifdef SNES_PAD_DETECT_EN
    output logic                connected_p1,
    output logic                connected_p2,
`endif
    output logic                busy
);

    localparam int                POLL_W    = $clog2(POLL_PERIOD + 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_PERIOD - 1);
    localparam int                BCNT_W    = $clog2(NUM_BITS + 1);
    localparam logic [BCNT_W-1:0] BITS_END  = BCNT_W'(NUM_BITS);
    localparam logic              LATCH_END = 1'(LATCH_TICKS - 1);

    snes_state_t         r_state;
    logic [POLL_W-1:0]   r_pollCnt;
    logic [BCNT_W-1:0]   r_bitCnt;
    logic                r_latchCnt;
    logic [1:0]          r_syncP1;
    logic [1:0]          r_syncP2;
    logic [NUM_BITS-1:0] r_shiftP1;
    logic [NUM_BITS-1:0] r_shiftP2;
`ifdef SNES_PAD_DETECT_EN
    logic                r_levelP1;
    logic                r_levelP2;
`endif

    logic w_tickClear;
    logic w_tickEnd;
    logic w_sampleP1;
    logic w_sampleP2;

    // Outside the timed phases the tick is held at zero, so the first
    // tick of LATCH is full length no matter how the frame was started.
    assign w_tickClear = (r_state == IDLE) || (r_state == DONE);

    // Pads pull the line low for a pressed button
    assign w_sampleP1 = ~r_syncP1[1];
    assign w_sampleP2 = ~r_syncP2[1];

    snes_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tickGen (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_tickClear),
        .o_tickEnd (w_tickEnd)
    );

    // Two-flop synchronisers for the asynchronous pad data lines. They
    // reset to the idle-high level so nothing looks pressed.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_syncP1 <= 2'b11;
            r_syncP2 <= 2'b11;
        end else begin
            r_syncP1 <= {r_syncP1[0], pad_data_p1};
            r_syncP2 <= {r_syncP2[0], pad_data_p2};
        end
    end

    // Frame sequencer. Bits enter the shift registers at the top and move
    // down, so after NUM_BITS samples the first bit (B) sits in bit 0.
    // The button outputs are only written in DONE, which keeps partial
    // frames invisible to the processor.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pollCnt   <= '0;
            r_bitCnt    <= '0;
            r_latchCnt  <= 1'b0;
            r_shiftP1   <= '0;
            r_shiftP2   <= '0;
            pad_latch   <= 1'b0;
            pad_clk     <= 1'b1;
            buttons_p1  <= '0;
            buttons_p2  <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
`ifdef SNES_PAD_DETECT_EN
            r_levelP1    <= 1'b1;
            r_levelP2    <= 1'b1;
            connected_p1 <= 1'b0;
            connected_p2 <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if ((r_pollCnt == POLL_LAST) || poll_req) begin
                        r_pollCnt  <= '0;
                        r_latchCnt <= 1'b0;
                        pad_latch  <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= LATCH;
                    end else begin
                        r_pollCnt <= r_pollCnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (w_tickEnd) begin
                        if (r_latchCnt == LATCH_END) begin
                            r_shiftP1 <= {w_sampleP1, r_shiftP1[NUM_BITS-1:1]};
                            r_shiftP2 <= {w_sampleP2, r_shiftP2[NUM_BITS-1:1]};
                            r_bitCnt  <= BCNT_W'(1);
                            pad_latch <= 1'b0;
                            pad_clk   <= 1'b0;
                            r_state   <= CLK_LO;
                        end else begin
                            r_latchCnt <= r_latchCnt + 1'b1;
                        end
                    end
                end
                CLK_LO: begin
                    if (w_tickEnd) begin
                        pad_clk <= 1'b1;
                        r_state <= CLK_HI;
                    end
                end
                CLK_HI: begin
                    if (w_tickEnd) begin
                        if (r_bitCnt < BITS_END) begin
                            r_shiftP1 <= {w_sampleP1, r_shiftP1[NUM_BITS-1:1]};
                            r_shiftP2 <= {w_sampleP2, r_shiftP2[NUM_BITS-1:1]};
                            r_bitCnt  <= r_bitCnt + 1'b1;
                            pad_clk   <= 1'b0;
                            r_state   <= CLK_LO;
                        end else begin
`ifdef SNES_PAD_DETECT_EN
                            // A present pad drives low past its last bit;
                            // an absent one floats high on the pull-up.
                            r_levelP1 <= r_syncP1[1];
                            r_levelP2 <= r_syncP2[1];
`endif
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
`ifdef SNES_PAD_DETECT_EN
                    connected_p1 <= ~r_levelP1;
                    connected_p2 <= ~r_levelP2;
                    buttons_p1   <= r_levelP1 ? '0 : r_shiftP1;
                    buttons_p2   <= r_levelP2 ? '0 : r_shiftP2;
`else
                    buttons_p1 <= r_shiftP1;
                    buttons_p2 <= r_shiftP2;
`endif
                    r_bitCnt    <= '0;
                    frame_valid <= 1'b1;
                    busy        <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snes_pad_reader.sv
// tb_snes_pad_reader
// Directed bench for snes_pad_reader with CLK_DIV=4, POLL_PERIOD=100.
// Two behavioural pads load their active-low word on LATCH rise and shift
// on every CLK rise, driving low once all bits are out.

module tb_snes_pad_reader;

    localparam int CLK_DIV     = 4;
    localparam int POLL_PERIOD = 100;
    localparam int NUM_BITS    = 16;
    localparam int FRAME_CLKS  = (2 + 2 * NUM_BITS) * CLK_DIV + 1;
    localparam int WAIT_LIMIT  = 1000;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                poll_req = 1'b0;
    logic                pad_data_p1;
    logic                pad_data_p2;
    logic                pad_latch;
    logic                pad_clk;
    logic [NUM_BITS-1:0] buttons_p1;
    logic [NUM_BITS-1:0] buttons_p2;
    logic                frame_valid;
    logic                busy;
`ifdef SNES_PAD_DETECT_EN
    logic                connected_p1;
    logic                connected_p2;
`endif

    int passCount  = 0;
    int checkCount = 0;
    int cycleCount = 0;
    int clkFalls   = 0;

    logic [15:0] padWordP1 = 16'hFFFF;
    logic [15:0] padWordP2 = 16'hFFFF;
    logic [15:0] padShiftP1 = 16'hFFFF;
    logic [15:0] padShiftP2 = 16'hFFFF;
    logic        padPresentP2 = 1'b1;

    snes_pad_reader #(
        .CLK_DIV     (CLK_DIV),
        .POLL_PERIOD (POLL_PERIOD),
        .NUM_BITS    (NUM_BITS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pad_data_p1  (pad_data_p1),
        .pad_data_p2  (pad_data_p2),
        .poll_req     (poll_req),
        .pad_latch    (pad_latch),
        .pad_clk      (pad_clk),
        .buttons_p1   (buttons_p1),
        .buttons_p2   (buttons_p2),
        .frame_valid  (frame_valid),
`ifdef SNES_PAD_DETECT_EN
        .connected_p1 (connected_p1),
        .connected_p2 (connected_p2),
`endif
        .busy         (busy)
    );

    // 100 MHz-style clock; only the cycle count matters here
    always #5 clock = ~clock;

    // Absolute cycle counter used to time frames from the LATCH rise
    always @(posedge clock) cycleCount <= cycleCount + 1;

    // Counts CLK pulses sent to the pads
    always @(negedge pad_clk) clkFalls <= clkFalls + 1;

    // Pad model: parallel load while LATCH rises, shift on CLK rise
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch === 1'b1) begin
            padShiftP1 <= padWordP1;
            padShiftP2 <= padWordP2;
        end else begin
            padShiftP1 <= {1'b0, padShiftP1[15:1]};
            padShiftP2 <= {1'b0, padShiftP2[15:1]};
        end
    end

    assign pad_data_p1 = padShiftP1[0];
    assign pad_data_p2 = padPresentP2 ? padShiftP2[0] : 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) until a DUT output reaches a level, sampling 1 ns
    // after each rising clock edge. which: 0 latch, 1 pad clk, 2 valid.
    task automatic waitSignal(input int which, input logic level, output int edges);
        logic sig;
        edges = 0;
        sig   = ~level;
        while ((sig !== level) && (edges < WAIT_LIMIT)) begin
            @(posedge clock);
            #1;
            edges++;
            case (which)
                0:       sig = pad_latch;
                1:       sig = pad_clk;
                default: sig = frame_valid;
            endcase
        end
    endtask

    // Loads new pad words and pulses poll_req for one cycle; returns
    // 1 ns after the edge that sampled the request.
    task automatic applyStimulus(input logic [15:0] wordP1, input logic [15:0] wordP2);
        @(negedge clock);
        padWordP1 = wordP1;
        padWordP2 = wordP2;
        poll_req  = 1'b1;
        @(posedge clock);
        #1;
        poll_req = 1'b0;
    endtask

    initial begin
        int n;
        int latchCycle;
        int fallsAtLatch;
        int holdWrong;
        int rises;
        logic prevClk;

        // ---- Reset state ----
        repeat (3) @(posedge clock);
        #1;
        checkOutput("resetLatch", pad_latch, 0);
        checkOutput("resetPadClk", pad_clk, 1);
        checkOutput("resetButtonsP1", buttons_p1, 0);
        checkOutput("resetButtonsP2", buttons_p2, 0);
        checkOutput("resetValid", frame_valid, 0);
        checkOutput("resetBusy", busy, 0);

        // ---- Frame 1: timer-started, B and A pressed on pad 1 ----
        padWordP1 = 16'hFEFE;
        padWordP2 = 16'hFFFF;
        @(negedge clock);
        reset = 1'b0;
        waitSignal(0, 1'b1, n);
        checkOutput("pollDelay", n, POLL_PERIOD);
        checkOutput("busyInLatch", busy, 1);
        latchCycle   = cycleCount;
        fallsAtLatch = clkFalls;
        waitSignal(0, 1'b0, n);
        checkOutput("latchWidth", n, 2 * CLK_DIV);
        for (int i = 0; i < NUM_BITS; i++) begin
            waitSignal(1, 1'b1, n);
            checkOutput($sformatf("clkLow%0d", i), n, CLK_DIV);
            if (i < NUM_BITS - 1) begin
                waitSignal(1, 1'b0, n);
                checkOutput($sformatf("clkHigh%0d", i), n, CLK_DIV);
            end
        end
        waitSignal(2, 1'b1, n);
        checkOutput("frameTime1", cycleCount - latchCycle, FRAME_CLKS);
        checkOutput("clkPulses", clkFalls - fallsAtLatch, NUM_BITS);
        checkOutput("buttonsP1_BA", buttons_p1, 16'h0101);
        checkOutput("buttonsP2_none", buttons_p2, 16'h0000);
        checkOutput("busyAtValid", busy, 0);
        @(posedge clock);
        #1;
        checkOutput("validOneCycle", frame_valid, 0);

        // ---- Frame 2: poll_req start, stray poll_req mid-frame ----
        applyStimulus(16'hFFFE, 16'hFFFF);
        checkOutput("pollReqLatch", pad_latch, 1);
        latchCycle = cycleCount;
        repeat (49) @(posedge clock);
        @(negedge clock);
        poll_req = 1'b1;
        @(posedge clock);
        #1;
        poll_req = 1'b0;
        checkOutput("busyMidFrame", busy, 1);
        checkOutput("latchMidFrame", pad_latch, 0);
        waitSignal(2, 1'b1, n);
        checkOutput("frameTime2", cycleCount - latchCycle, FRAME_CLKS);
        checkOutput("buttonsP1_B", buttons_p1, 16'h0001);
        repeat (5) @(posedge clock);
        #1;
        checkOutput("noQueuedFrame", pad_latch, 0);
        checkOutput("noQueuedBusy", busy, 0);

        // ---- Frame 3: word changes, old value held until DONE ----
        applyStimulus(16'hF7FF, 16'hFFFF);
        latchCycle = cycleCount;
        holdWrong  = 0;
        n          = 0;
        while ((frame_valid !== 1'b1) && (n < WAIT_LIMIT)) begin
            if (buttons_p1 !== 16'h0001) holdWrong++;
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput("holdPrevWord", holdWrong, 0);
        checkOutput("frameTime3", cycleCount - latchCycle, FRAME_CLKS);
        checkOutput("buttonsP1_R", buttons_p1, 16'h0800);

        // ---- Frame 4: reset during the 9th CLK high phase ----
        applyStimulus(16'hFEFE, 16'hFFFF);
        rises   = 0;
        n       = 0;
        prevClk = pad_clk;
        while ((rises < 9) && (n < WAIT_LIMIT)) begin
            @(posedge clock);
            #1;
            n++;
            if (pad_clk && !prevClk) rises++;
            prevClk = pad_clk;
        end
        checkOutput("ninthClkRise", rises, 9);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("abortPadClk", pad_clk, 1);
        checkOutput("abortLatch", pad_latch, 0);
        checkOutput("abortButtonsP1", buttons_p1, 0);
        checkOutput("abortBusy", busy, 0);
        @(negedge clock);
        reset = 1'b0;

        // Timer expiry and poll_req land on the same cycle: one frame
        repeat (POLL_PERIOD - 1) @(posedge clock);
        #1;
        checkOutput("latchBeforePeriod", pad_latch, 0);
        @(negedge clock);
        poll_req = 1'b1;
        @(posedge clock);
        #1;
        poll_req = 1'b0;
        checkOutput("latchAfterReset", pad_latch, 1);
        latchCycle = cycleCount;
        waitSignal(2, 1'b1, n);
        checkOutput("frameTime4", cycleCount - latchCycle, FRAME_CLKS);
        checkOutput("buttonsP1_after", buttons_p1, 16'h0101);
        repeat (5) @(posedge clock);
        #1;
        checkOutput("singleFrame", pad_latch, 0);

`ifdef SNES_PAD_DETECT_EN
        // ---- Pad 2 absent: line floats high ----
        checkOutput("connectedP2Present", connected_p2, 1);
        padPresentP2 = 1'b0;
        applyStimulus(16'hFEFE, 16'h0000);
        waitSignal(2, 1'b1, n);
        checkOutput("connectedP1", connected_p1, 1);
        checkOutput("connectedP2", connected_p2, 0);
        checkOutput("absentButtonsP2", buttons_p2, 0);
        checkOutput("presentButtonsP1", buttons_p1, 16'h0101);
`endif

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Safety net in case a wait loop is never satisfied
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
